// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
//   arb_state_t : sequencer states (IDLE, ISSUE, WAIT, ACK)
//   ADDR_W      : default memory address width
//   DATA_W      : default memory data width
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker.
// The search starts one position after the previous winner and wraps
// modulo NREQ, so the most recently served requester has lowest priority.
//   req      : request vector
//   last_gnt : index of the previously granted requester
//   win_oh   : one-hot winner (all zero when nothing requests)
//   win_idx  : binary index of the winner (0 when nothing requests)
//   valid    : at least one request present
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_gnt,
    output logic [NREQ-1:0]  win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             valid
);

    int               cand_s;
    logic [IDX_W-1:0] cand_idx_s;

    // Walk the requesters in rotating priority order and keep the first hit.
    always_comb begin
        win_oh     = '0;
        win_idx    = '0;
        valid      = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s     = (int'(last_gnt) + k) % NREQ;
            cand_idx_s = IDX_W'(cand_s);
            if (!valid && req[cand_idx_s]) begin
                valid           = 1'b1;
                win_oh          = '0;
                win_oh[cand_idx_s] = 1'b1;
                win_idx         = cand_idx_s;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port memory between
// NREQ requesters. One access per grant: strobe for one cycle, wait out the
// read latency, then pulse ack with the captured read data.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   req, req_wr      : per-requester request level and write flag
//   req_addr         : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata        : packed write data, requester i at [i*DATA_W +: DATA_W]
//   gnt              : one-hot, high while a requester is being served
//   ack              : one-cycle completion pulse to the served requester
//   rdata            : read data, valid in the ack cycle of a read (held)
//   en, wr, addr, wdata : memory strobe and command, zero outside ISSUE
//   mem_rdata        : memory read data
module mem_port_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_wr,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          ack,
    output logic [DATA_W-1:0]        rdata,
    output logic                     en,
    output logic                     wr,
    output logic [ADDR_W-1:0]        addr,
    output logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    import mem_arb_pkg::*;

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    arb_state_t        state_r, state_nxt_s;
    logic [IDX_W-1:0]  last_gnt_r, last_gnt_nxt_s;
    logic              lat_wr_r, lat_wr_nxt_s;
    logic [ADDR_W-1:0] lat_addr_r, lat_addr_nxt_s;
    logic [DATA_W-1:0] lat_wdata_r, lat_wdata_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [DATA_W-1:0] rdata_r, rdata_nxt_s;

    logic [NREQ-1:0]   gnt_r, gnt_nxt_s;
    logic [NREQ-1:0]   ack_r, ack_nxt_s;
    logic              en_r, en_nxt_s;
    logic              wr_r, wr_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic [DATA_W-1:0] wdata_r, wdata_nxt_s;

    logic [NREQ-1:0]   pick_oh_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic              pick_valid_s;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .last_gnt (last_gnt_r),
        .win_oh   (pick_oh_s),
        .win_idx  (pick_idx_s),
        .valid    (pick_valid_s)
    );

    // Next-state, latch and output decode; outputs are derived from the
    // next state so every output port comes straight from a flop.
    always_comb begin
        state_nxt_s     = state_r;
        last_gnt_nxt_s  = last_gnt_r;
        lat_wr_nxt_s    = lat_wr_r;
        lat_addr_nxt_s  = lat_addr_r;
        lat_wdata_nxt_s = lat_wdata_r;
        cnt_nxt_s       = cnt_r;
        rdata_nxt_s     = rdata_r;
        gnt_nxt_s       = gnt_r;

        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s     = ISSUE;
                    last_gnt_nxt_s  = pick_idx_s;
                    lat_wr_nxt_s    = req_wr[pick_idx_s];
                    lat_addr_nxt_s  = req_addr[pick_idx_s*ADDR_W +: ADDR_W];
                    lat_wdata_nxt_s = req_wdata[pick_idx_s*DATA_W +: DATA_W];
                    gnt_nxt_s       = pick_oh_s;
                end else begin
                    gnt_nxt_s = '0;
                end
            end
            ISSUE: begin
                if (lat_wr_r) begin
                    state_nxt_s = ACK;
                end else begin
                    state_nxt_s = WAIT;
                    cnt_nxt_s   = CNT_W'(RD_LAT - 1);
                end
            end
            WAIT: begin
                // Counter reaching zero marks the last WAIT cycle; the edge
                // that ends it is the one where mem_rdata is valid.
                if (cnt_r == '0) begin
                    state_nxt_s = ACK;
                    rdata_nxt_s = mem_rdata;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            ACK: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = '0;
            end
            default: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = '0;
            end
        endcase

        if (state_nxt_s == ISSUE) begin
            en_nxt_s    = 1'b1;
            wr_nxt_s    = lat_wr_nxt_s;
            addr_nxt_s  = lat_addr_nxt_s;
            wdata_nxt_s = lat_wdata_nxt_s;
        end else begin
            en_nxt_s    = 1'b0;
            wr_nxt_s    = 1'b0;
            addr_nxt_s  = '0;
            wdata_nxt_s = '0;
        end

        if (state_nxt_s == ACK) begin
            ack_nxt_s = gnt_nxt_s;
        end else begin
            ack_nxt_s = '0;
        end
    end

    // Sequencer state, round-robin pointer, wait counter and request latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            last_gnt_r  <= IDX_W'(NREQ - 1);
            cnt_r       <= '0;
            lat_wr_r    <= 1'b0;
            lat_addr_r  <= '0;
            lat_wdata_r <= '0;
        end else begin
            state_r     <= state_nxt_s;
            last_gnt_r  <= last_gnt_nxt_s;
            cnt_r       <= cnt_nxt_s;
            lat_wr_r    <= lat_wr_nxt_s;
            lat_addr_r  <= lat_addr_nxt_s;
            lat_wdata_r <= lat_wdata_nxt_s;
        end
    end

    // Output registers, including the held read-data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r   <= '0;
            ack_r   <= '0;
            en_r    <= 1'b0;
            wr_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
        end else begin
            gnt_r   <= gnt_nxt_s;
            ack_r   <= ack_nxt_s;
            en_r    <= en_nxt_s;
            wr_r    <= wr_nxt_s;
            addr_r  <= addr_nxt_s;
            wdata_r <= wdata_nxt_s;
            rdata_r <= rdata_nxt_s;
        end
    end

    assign gnt   = gnt_r;
    assign ack   = ack_r;
    assign en    = en_r;
    assign wr    = wr_r;
    assign addr  = addr_r;
    assign wdata = wdata_r;
    assign rdata = rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (NREQ=2, RD_LAT=1).
// A transaction-level model tracks the access in flight by its age in
// cycles; a compare process checks every cycle, and directed sequences
// pin literal values from hand calculation.
module tb_mem_port_arbiter;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_wr;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0]      mem_rdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        ack;
    logic [DATA_W-1:0]      rdata;
    logic                   en;
    logic                   wr;
    logic [ADDR_W-1:0]      addr;
    logic [DATA_W-1:0]      wdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .en        (en),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .mem_rdata (mem_rdata)
    );

    always #20 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic              m_active;
    int                m_age;
    int                m_w;
    int                m_last;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    int                nxt_w;

    function automatic int rr_winner(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        return NREQ'(1) << i;
    endfunction

    function automatic int txn_len(input logic is_wr);
        return is_wr ? 2 : 2 + RD_LAT;
    endfunction

    always_comb nxt_w = rr_winner(req, m_last);

    // Model: an access is (winner, fields, age); age 1 is the strobe cycle,
    // the last age is the ack cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_w      <= 0;
            m_last   <= NREQ - 1;
            m_wr     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_rdata  <= '0;
        end else if (m_active) begin
            if (!m_wr && m_age == 1 + RD_LAT) m_rdata <= mem_rdata;
            if (m_age == txn_len(m_wr)) m_active <= 1'b0;
            else m_age <= m_age + 1;
        end else if (nxt_w >= 0) begin
            m_active <= 1'b1;
            m_age    <= 1;
            m_w      <= nxt_w;
            m_last   <= nxt_w;
            m_wr     <= req_wr[nxt_w];
            m_addr   <= req_addr[nxt_w*ADDR_W +: ADDR_W];
            m_wdata  <= req_wdata[nxt_w*DATA_W +: DATA_W];
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        check("gnt", 32'(gnt), m_active ? 32'(onehot(m_w)) : 32'd0);
        check("ack", 32'(ack), (m_active && m_age == txn_len(m_wr)) ? 32'(onehot(m_w)) : 32'd0);
        check("en", 32'(en), (m_active && m_age == 1) ? 32'd1 : 32'd0);
        check("wr", 32'(wr), (m_active && m_age == 1) ? 32'(m_wr) : 32'd0);
        check("addr", 32'(addr), (m_active && m_age == 1) ? 32'(m_addr) : 32'd0);
        check("wdata", 32'(wdata), (m_active && m_age == 1) ? 32'(m_wdata) : 32'd0);
        check("rdata", 32'(rdata), 32'(m_rdata));
        check("ack_single", ($countones(ack) <= 1) ? 32'd1 : 32'd0, 32'd1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    int en_cyc[$];
    int en_addr[$];
    int ack_seq[$];

    initial begin
        rst_n = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0; mem_rdata = '0;
        repeat (3) tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_en", 32'(en), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single write from requester 0; address changes during ISSUE.
        req = 2'b01; req_wr = 2'b01; req_addr[5:0] = 6'd12; req_wdata[7:0] = 8'hA5;
        tick();
        check("wr1_en", 32'(en), 32'd1);
        check("wr1_wr", 32'(wr), 32'd1);
        check("wr1_addr", 32'(addr), 32'd12);
        check("wr1_wdata", 32'(wdata), 32'hA5);
        check("wr1_gnt", 32'(gnt), 32'h1);
        req_addr[5:0] = 6'd56; req = 2'b00;
        tick();
        check("wr1_ack", 32'(ack), 32'h1);
        check("wr1_gnt2", 32'(gnt), 32'h1);
        check("wr1_en2", 32'(en), 32'd0);
        tick();
        check("wr1_idle_gnt", 32'(gnt), 32'd0);
        check("wr1_idle_ack", 32'(ack), 32'd0);

        // Single read from requester 1.
        req = 2'b10; req_wr = 2'b00; req_addr[11:6] = 6'd23;
        tick();
        check("rd1_en", 32'(en), 32'd1);
        check("rd1_wr", 32'(wr), 32'd0);
        check("rd1_addr", 32'(addr), 32'd23);
        check("rd1_gnt", 32'(gnt), 32'h2);
        req = 2'b00; req_addr[11:6] = 6'd1; mem_rdata = 8'h3C;
        tick();
        check("rd1_wait_en", 32'(en), 32'd0);
        check("rd1_wait_ack", 32'(ack), 32'd0);
        check("rd1_wait_gnt", 32'(gnt), 32'h2);
        tick();
        check("rd1_ack", 32'(ack), 32'h2);
        check("rd1_rdata", 32'(rdata), 32'h3C);
        mem_rdata = 8'h77;
        tick();

        // Contention: both write continuously.
        req = 2'b11; req_wr = 2'b11;
        req_addr[5:0] = 6'd14; req_addr[11:6] = 6'd48;
        req_wdata[7:0] = 8'h11; req_wdata[15:8] = 8'h22;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (en) begin
                en_cyc.push_back(c);
                en_addr.push_back(int'(addr));
            end
            if (ack != 2'b00) ack_seq.push_back(int'(ack));
        end
        req = 2'b00;
        repeat (3) tick();
        check("cont_en_count", 32'(en_cyc.size()), 32'd4);
        check("cont_ack_count", 32'(ack_seq.size()), 32'd4);
        if (en_cyc.size() == 4 && ack_seq.size() == 4) begin
            check("cont_en_first", 32'(en_cyc[0]), 32'd1);
            for (int i = 0; i < 4; i++) begin
                check("cont_addr", 32'(en_addr[i]), (i % 2 == 0) ? 32'd14 : 32'd48);
                check("cont_ack", 32'(ack_seq[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
                if (i > 0) check("cont_spacing", 32'(en_cyc[i] - en_cyc[i-1]), 32'd3);
            end
        end
        check("cont_rdata_hold", 32'(rdata), 32'h3C);

        // Reset during WAIT of a read.
        req = 2'b01; req_wr = 2'b00; req_addr[5:0] = 6'd5;
        tick();
        check("rr_gnt_issue", 32'(gnt), 32'h1);
        req = 2'b00;
        tick();
        check("rr_gnt_wait", 32'(gnt), 32'h1);
        #5 rst_n = 1'b0;
        #1;
        check("rr_async_gnt", 32'(gnt), 32'd0);
        check("rr_async_ack", 32'(ack), 32'd0);
        check("rr_async_en", 32'(en), 32'd0);
        check("rr_async_rdata", 32'(rdata), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        req = 2'b11; req_wr = 2'b11;
        tick();
        check("rr_first_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        repeat (3) tick();

        // Idle: nothing moves for 20 cycles.
        for (int c = 0; c < 20; c++) begin
            tick();
            check("idle_quiet", 32'({en, gnt, ack}), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter and sequencer that shares one single-port memory interface (en, wr, 6-bit addr) between NREQ requesters on the 25 MHz clk domain. Each granted requester gets exactly one access. The block drives the memory strobe for one cycle, waits out the fixed read latency, then returns an ack with captured read data. It sits between the bus clients and the memory model/RAM that the team's stimulus tasks exercise.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- ADDR_W, 6, memory address width
- DATA_W, 8, data width
- RD_LAT, 1, cycles from en-with-wr=0 to mem_rdata valid (1..4)

Ports:
- clk  in  1  single clock, 25 MHz nominal, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester access request, level
- req_wr  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  packed write data
- gnt  out  NREQ  one-hot, high for the requester being served
- ack  out  NREQ  one-cycle completion pulse to the served requester
- rdata  out  DATA_W  read data, valid in the ack cycle of a read
- en  out  1  memory strobe
- wr  out  1  memory write enable
- addr  out  ADDR_W  memory address
- wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states are IDLE, ISSUE, WAIT and ACK.
- IDLE: if any req bit is high, pick the winner round-robin, latch its wr/addr/wdata and go to ISSUE. Otherwise stay in IDLE.
- Round-robin: search starts at last_gnt+1 modulo NREQ. last_gnt resets to NREQ-1, so requester 0 wins first. last_gnt updates on entry to ISSUE.
- ISSUE (1 cycle): en=1 and wr/addr/wdata come from the latched values. A write goes to ACK. A read goes to WAIT.
- WAIT (RD_LAT cycles, counter): at the end of the final WAIT cycle, mem_rdata is captured into rdata. Then go to ACK.
- ACK (1 cycle): ack[winner]=1. Return to IDLE.
- gnt[winner] is high in ISSUE, WAIT and ACK; it is 0 in IDLE.
- en=0 in every state except ISSUE. In other states wr, addr and wdata are 0.
- Request fields are latched at the grant edge. Changes to a requester's inputs after that edge do not affect the access in flight.
- Dropping req after the grant does not cancel the access; it completes and acks normally.
- A requester that drops req before being granted is simply skipped.
- rdata holds its last captured value and is not cleared on writes.

## Timing
- Reset (asynchronous assert, synchronous-release behaviour on clk):
  - all outputs 0, rdata 0, state IDLE, last_gnt = NREQ-1
  - any in-flight access is abandoned with no ack
- Write latency: req sampled in IDLE at edge 0 → ISSUE in cycle 1 (en=1, wr=1) → ACK in cycle 2 → IDLE in cycle 3.
- Read latency: ISSUE in cycle 1 → WAIT in cycles 2..1+RD_LAT → ACK in cycle 2+RD_LAT.
- mem_rdata is sampled on the posedge ending cycle 1+RD_LAT.
- Minimum spacing between en pulses is 3 cycles for writes and 3+RD_LAT cycles for reads.
- No arbitration happens in ACK. A request held high through ACK is arbitrated in the following IDLE cycle.
- With all requesters continuously requesting, grants rotate 0,1,…,NREQ-1,0 with no starvation.

## Structure
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} arb_state_t
  - default width localparams ADDR_W=6 and DATA_W=8
- Sub-module rr_pick is combinational: given req and last_gnt, it returns a one-hot winner and its index. It is instantiated once.
- The top level holds the FSM, latch registers, the WAIT counter (width $clog2(RD_LAT+1)) and the rdata register.

## Test plan
- Single write: req[0]=1, wr=1, addr=12, wdata=0xA5 → en=1/wr=1/addr=12 in cycle 1, ack[0] in cycle 2, gnt=2'b01 in cycles 1–2.
- Single read, RD_LAT=1: req[1]=1, wr=0, addr=23, mem_rdata=0x3C in cycle 2 → en=1/wr=0/addr=23 in cycle 1, ack[1] with rdata=0x3C in cycle 3.
- Contention: both request continuously, writes to 14 and 48 → served order 0,1,0,1; en pulses 3 cycles apart; ack never asserted for both requesters at once.
- Field change after grant: requester 0 changes addr 12→56 in the ISSUE cycle → memory sees addr=12.
- Reset mid-read: assert rst_n=0 during WAIT → all outputs 0 immediately, no ack. After release, the first grant goes to requester 0.
- Idle: req=0 for 20 cycles → en, gnt and ack stay 0.
